// File: rtl/bp_me_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bp_me_burst_rr_arbiter
//
// Purpose:
//   Merges num_ch_p BP Burst (ready&valid) message streams onto one BP Burst
//   output port. A channel's header is passed through combinationally. If that
//   message carries data, the channel keeps the grant until its last data beat
//   has handshaken. Header and data beats of different messages therefore
//   never interleave on the output. The next message is chosen round-robin.
//
// Build option:
//   BP_ME_BURST_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid
//   channel always wins and no round-robin pointer is built. Grant and hold
//   behaviour are the same as in the default build. When undefined (the
//   default), arbitration is round-robin.
//
// Ports:
//   clk_i                 clock
//   reset_i               synchronous active-high reset
//   header_i              per-channel headers, channel i at [i*header_width_p +: header_width_p]
//   header_v_i            per-channel header valid
//   header_ready_and_o    per-channel header ready (only the selected channel sees downstream ready)
//   has_data_i            per-channel "message carries data beats"
//   data_i                per-channel data beat, channel i at [i*data_width_p +: data_width_p]
//   data_v_i              per-channel data valid
//   data_ready_and_o      per-channel data ready (only the granted channel sees downstream ready)
//   last_i                per-channel last-beat flag
//   header_o              selected header
//   header_v_o            output header valid
//   header_ready_and_i    downstream header ready
//   has_data_o            selected has_data
//   data_o                granted channel data beat
//   data_v_o              output data valid
//   data_ready_and_i      downstream data ready
//   last_o                granted channel last flag
//   grant_id_o            channel currently selected (header phase) or granted (data phase)
// -----------------------------------------------------------------------------
module bp_me_burst_rr_arbiter #(
    parameter  int num_ch_p       = 2,
    parameter  int header_width_p = 64,
    parameter  int data_width_p   = 64,
    localparam int lg_num_ch_lp   = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,

    input  logic [num_ch_p*header_width_p-1:0] header_i,
    input  logic [num_ch_p-1:0]                header_v_i,
    output logic [num_ch_p-1:0]                header_ready_and_o,
    input  logic [num_ch_p-1:0]                has_data_i,

    input  logic [num_ch_p*data_width_p-1:0]   data_i,
    input  logic [num_ch_p-1:0]                data_v_i,
    output logic [num_ch_p-1:0]                data_ready_and_o,
    input  logic [num_ch_p-1:0]                last_i,

    output logic [header_width_p-1:0]          header_o,
    output logic                               header_v_o,
    input  logic                               header_ready_and_i,
    output logic                               has_data_o,

    output logic [data_width_p-1:0]            data_o,
    output logic                               data_v_o,
    input  logic                               data_ready_and_i,
    output logic                               last_o,

    output logic [lg_num_ch_lp-1:0]            grant_id_o
);

    // e_ready: headers are being arbitrated.
    // e_data : a message with data holds the grant until its last beat.
    typedef enum logic {
        e_ready = 1'b0,
        e_data  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [lg_num_ch_lp-1:0] r_grant;

    logic [lg_num_ch_lp-1:0] w_sel;
    logic                    w_hdr_hs;
    logic                    w_data_last_hs;

`ifndef BP_ME_BURST_ARB_FIXED_PRIO_EN
    logic [lg_num_ch_lp-1:0] r_rr_ptr;

    // Modulo-num_ch_p increment; works for non-power-of-two channel counts.
    function automatic logic [lg_num_ch_lp-1:0] f_next(input logic [lg_num_ch_lp-1:0] p);
        if (int'(p) == num_ch_p - 1) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Header selection.
    // Round-robin: scan rr_ptr, rr_ptr+1, ... wrapping at num_ch_p.
    // Fixed priority: scan from channel 0 upward.
    // -------------------------------------------------------------------------
    always_comb begin
        int  idx;
        logic found;
        w_sel = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < num_ch_p; k++) begin
`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(r_rr_ptr) + k;
            if (idx >= num_ch_p) begin
                idx = idx - num_ch_p;
            end
`endif
            if (!found && header_v_i[idx]) begin
                found = 1'b1;
                w_sel = lg_num_ch_lp'(idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output steering. Payloads are muxed unconditionally. Valid and ready
    // bits are forced low while reset is held, so that a message left open
    // does not leak out during the reset cycles. Valids depend only on the
    // inputs' valids and registered state, never on ready inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        header_o           = header_i[w_sel*header_width_p +: header_width_p];
        has_data_o         = has_data_i[w_sel];
        data_o             = data_i[r_grant*data_width_p +: data_width_p];
        last_o             = last_i[r_grant];

        header_v_o         = 1'b0;
        header_ready_and_o = '0;
        data_v_o           = 1'b0;
        data_ready_and_o   = '0;
        grant_id_o         = '0;

        if (!reset_i) begin
            case (r_state)
                e_ready: begin
                    header_v_o                = |header_v_i;
                    header_ready_and_o[w_sel] = header_ready_and_i;
                    grant_id_o                = w_sel;
                end
                e_data: begin
                    data_v_o                    = data_v_i[r_grant];
                    data_ready_and_o[r_grant]   = data_ready_and_i;
                    grant_id_o                  = r_grant;
                end
                default: begin
                    grant_id_o = '0;
                end
            endcase
        end
    end

    // header_v_o is only high in e_ready, and data_v_o is only high in e_data,
    // so these two events are mutually exclusive.
    assign w_hdr_hs       = header_v_o & header_ready_and_i;
    assign w_data_last_hs = data_v_o & data_ready_and_i & last_i[r_grant];

    // -------------------------------------------------------------------------
    // State, grant and round-robin pointer.
    // A header-only message completes on its header handshake, so the pointer
    // moves past it right away. A message with data leaves the pointer alone
    // until its last beat, so the pointer moves once per message.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= e_ready;
            r_grant  <= '0;
`ifndef BP_ME_BURST_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            if (w_hdr_hs && has_data_i[w_sel]) begin
                r_grant <= w_sel;
                r_state <= e_data;
            end
            if (w_data_last_hs) begin
                r_state <= e_ready;
            end
`ifndef BP_ME_BURST_ARB_FIXED_PRIO_EN
            if (w_hdr_hs && !has_data_i[w_sel]) begin
                r_rr_ptr <= f_next(w_sel);
            end
            if (w_data_last_hs) begin
                r_rr_ptr <= f_next(r_grant);
            end
`endif
        end
    end

endmodule

// File: tb/tb_bp_me_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_me_burst_rr_arbiter
//
// Purpose:
//   Directed bench for bp_me_burst_rr_arbiter. It uses a 2-channel instance
//   (64-bit fields) and a 4-channel instance (16-bit fields). Expected values
//   are worked out by hand for each step. Where the expectation depends on the
//   arbitration mode, it follows BP_ME_BURST_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_bp_me_burst_rr_arbiter;

`ifdef BP_ME_BURST_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2-channel instance signals
    logic [127:0] h2;
    logic [1:0]   hv2, hr2, hd2;
    logic [127:0] dt2;
    logic [1:0]   dv2, dr2, l2;
    logic [63:0]  ho2, do2;
    logic         hvo2, hri2, hdo2, dvo2, dri2, lo2;
    logic         gid2;

    // 4-channel instance signals
    logic [63:0]  h4;
    logic [3:0]   hv4, hr4, hd4;
    logic [63:0]  dt4;
    logic [3:0]   dv4, dr4, l4;
    logic [15:0]  ho4, do4;
    logic         hvo4, hri4, hdo4, dvo4, dri4, lo4;
    logic [1:0]   gid4;

    int checks = 0;
    int errors = 0;

    bp_me_burst_rr_arbiter #(
        .num_ch_p(2), .header_width_p(64), .data_width_p(64)
    ) u_dut2 (
        .clk_i(clk), .reset_i(reset),
        .header_i(h2), .header_v_i(hv2), .header_ready_and_o(hr2), .has_data_i(hd2),
        .data_i(dt2), .data_v_i(dv2), .data_ready_and_o(dr2), .last_i(l2),
        .header_o(ho2), .header_v_o(hvo2), .header_ready_and_i(hri2), .has_data_o(hdo2),
        .data_o(do2), .data_v_o(dvo2), .data_ready_and_i(dri2), .last_o(lo2),
        .grant_id_o(gid2)
    );

    bp_me_burst_rr_arbiter #(
        .num_ch_p(4), .header_width_p(16), .data_width_p(16)
    ) u_dut4 (
        .clk_i(clk), .reset_i(reset),
        .header_i(h4), .header_v_i(hv4), .header_ready_and_o(hr4), .has_data_i(hd4),
        .data_i(dt4), .data_v_i(dv4), .data_ready_and_o(dr4), .last_i(l4),
        .header_o(ho4), .header_v_o(hvo4), .header_ready_and_i(hri4), .has_data_o(hdo4),
        .data_o(do4), .data_v_o(dvo4), .data_ready_and_i(dri4), .last_o(lo4),
        .grant_id_o(gid4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent0, sent1, exp_g;

        // ---------------- reset with every input valid ----------------
        reset = 1'b1;
        h2 = '0; hv2 = 2'b11; hd2 = 2'b11; dt2 = '0; dv2 = 2'b11; l2 = 2'b11;
        hri2 = 1'b1; dri2 = 1'b1;
        h4 = '0; hv4 = 4'hF; hd4 = 4'hF; dt4 = '0; dv4 = 4'hF; l4 = 4'hF;
        hri4 = 1'b1; dri4 = 1'b1;
        cyc();
        cyc();
        chk("rst_hv2",  64'(hvo2), 64'd0);
        chk("rst_hr2",  64'(hr2),  64'd0);
        chk("rst_dv2",  64'(dvo2), 64'd0);
        chk("rst_dr2",  64'(dr2),  64'd0);
        chk("rst_gid2", 64'(gid2), 64'd0);
        chk("rst_hv4",  64'(hvo4), 64'd0);
        chk("rst_hr4",  64'(hr4),  64'd0);
        chk("rst_dr4",  64'(dr4),  64'd0);

        // ---------------- single header-only message on ch1 ----------------
        reset = 1'b0;
        hv2 = 2'b10; hd2 = 2'b00; dv2 = 2'b00; l2 = 2'b00;
        h2[63:0] = 64'h111; h2[127:64] = 64'hABC;
        hv4 = 4'h0; hd4 = 4'h0; dv4 = 4'h0; l4 = 4'h0;
        #1;
        chk("single_ho",  ho2,          64'hABC);
        chk("single_hr",  64'(hr2),     64'd2);
        chk("single_gid", 64'(gid2),    64'd1);
        chk("single_hv",  64'(hvo2),    64'd1);
        chk("single_hd",  64'(hdo2),    64'd0);
        chk("single_dv",  64'(dvo2),    64'd0);
        cyc();

        // The pointer has wrapped to 0, so ch0 wins. Downstream is not ready,
        // so there is no handshake, but the valid stays asserted.
        hv2 = 2'b11; hri2 = 1'b0;
        #1;
        chk("wrap2_gid",    64'(gid2), 64'd0);
        chk("noready_hr",   64'(hr2),  64'd0);
        chk("noready_hv",   64'(hvo2), 64'd1);
        cyc();

        // ---------------- fairness: 4 header-only messages per channel ----------------
        hri2 = 1'b1;
        sent0 = 0;
        sent1 = 0;
        for (int i = 0; i < 8; i++) begin
            hv2 = {(sent1 < 4), (sent0 < 4)};
            exp_g = FIXED ? ((i < 4) ? 0 : 1) : (i % 2);
            #1;
            chk("fair_gid", 64'(gid2), 64'(exp_g));
            chk("fair_hr",  64'(hr2),  (exp_g == 1) ? 64'd2 : 64'd1);
            if (exp_g == 1) sent1++;
            else            sent0++;
            cyc();
        end

        // ---------------- burst hold: ch0 4 beats, ch1 header waiting ----------------
        hv2 = 2'b11; hd2 = 2'b01; h2[63:0] = 64'h5000; hri2 = 1'b1;
        #1;
        chk("burst_hdr_gid", 64'(gid2), 64'd0);
        chk("burst_hdr_hd",  64'(hdo2), 64'd1);
        chk("burst_hdr_hr",  64'(hr2),  64'd1);
        chk("burst_hdr_ho",  ho2,       64'h5000);
        cyc();
        for (int k = 0; k < 4; k++) begin
            dv2 = 2'b11;
            dt2[63:0]   = 64'h10 + 64'(k);
            dt2[127:64] = 64'hDEAD;
            l2 = {1'b1, (k == 3)};
            dri2 = 1'b1;
            #1;
            chk("hold_hv",  64'(hvo2), 64'd0);
            chk("hold_hr",  64'(hr2),  64'd0);
            chk("hold_do",  do2,       64'h10 + 64'(k));
            chk("hold_dv",  64'(dvo2), 64'd1);
            chk("hold_dr",  64'(dr2),  64'd1);
            chk("hold_lo",  64'(lo2),  (k == 3) ? 64'd1 : 64'd0);
            chk("hold_gid", 64'(gid2), 64'd0);
            cyc();
        end
        // Burst done: pointer now at 1, so ch1 wins over ch0 in round-robin.
        dv2 = 2'b00; l2 = 2'b00; hd2 = 2'b00; hv2 = 2'b11;
        #1;
        chk("post_burst_gid", 64'(gid2), FIXED ? 64'd0 : 64'd1);
        chk("post_burst_hr",  64'(hr2),  FIXED ? 64'd1 : 64'd2);
        chk("post_burst_hv",  64'(hvo2), 64'd1);
        chk("post_burst_dv",  64'(dvo2), 64'd0);
        cyc();

        // ---------------- backpressure: 2-beat burst on ch1 ----------------
        hv2 = 2'b10; hd2 = 2'b10; h2[127:64] = 64'h2; hri2 = 1'b1;
        #1;
        chk("bp_hdr_gid", 64'(gid2), 64'd1);
        chk("bp_hdr_hr",  64'(hr2),  64'd2);
        cyc();
        hv2 = 2'b00; dv2 = 2'b10; dt2[127:64] = 64'h20; l2 = 2'b00; dri2 = 1'b1;
        #1;
        chk("bp0_dv", 64'(dvo2), 64'd1);
        chk("bp0_dr", 64'(dr2),  64'd2);
        chk("bp0_do", do2,       64'h20);
        chk("bp0_lo", 64'(lo2),  64'd0);
        cyc();
        dt2[127:64] = 64'h21; l2 = 2'b10; dri2 = 1'b0;
        #1;
        chk("bp1_dv", 64'(dvo2), 64'd1);
        chk("bp1_dr", 64'(dr2),  64'd0);
        chk("bp1_do", do2,       64'h21);
        chk("bp1_lo", 64'(lo2),  64'd1);
        cyc();
        dri2 = 1'b1;
        #1;
        chk("bp2_dr", 64'(dr2),  64'd2);
        chk("bp2_do", do2,       64'h21);
        chk("bp2_hv", 64'(hvo2), 64'd0);
        cyc();
        // Last beat accepted: back in e_ready with the pointer at 0.
        dri2 = 1'b0; hv2 = 2'b11; hri2 = 1'b0; hd2 = 2'b00;
        #1;
        chk("bp3_dv",  64'(dvo2), 64'd0);
        chk("bp3_dr",  64'(dr2),  64'd0);
        chk("bp3_hv",  64'(hvo2), 64'd1);
        chk("bp3_gid", 64'(gid2), 64'd0);
        cyc();
        dv2 = 2'b00; l2 = 2'b00; hv2 = 2'b00;

        // ---------------- wrap-around on the 4-channel instance ----------------
        hv4 = 4'b0100; hd4 = 4'b0000; h4[47:32] = 16'h2222; hri4 = 1'b1;
        #1;
        chk("w4_gid", 64'(gid4), 64'd2);
        chk("w4_ho",  64'(ho4),  64'h2222);
        chk("w4_hr",  64'(hr4),  64'd4);
        cyc();
        // Pointer is 3: ch3 beats ch0 in round-robin.
        hv4 = 4'b1001; hri4 = 1'b0;
        #1;
        chk("w4_ptr3_gid", 64'(gid4), FIXED ? 64'd0 : 64'd3);
        chk("w4_ptr3_hr",  64'(hr4),  64'd0);
        cyc();
        // Pointer 3, valid on ch0 and ch2: the scan 3,0 finds ch0.
        hv4 = 4'b0101; hd4 = 4'b0001; hri4 = 1'b1;
        #1;
        chk("w4_sel_gid", 64'(gid4), 64'd0);
        chk("w4_sel_hr",  64'(hr4),  64'd1);
        cyc();
        hv4 = 4'b0000; dv4 = 4'b0001; dt4[15:0] = 16'h77; l4 = 4'b0001; dri4 = 1'b1;
        #1;
        chk("w4_do", 64'(do4), 64'h77);
        chk("w4_dr", 64'(dr4), 64'd1);
        chk("w4_lo", 64'(lo4), 64'd1);
        cyc();
        // Pointer is now 1: of ch0, ch1 and ch3, ch1 comes first.
        dv4 = 4'b0000; l4 = 4'b0000; hd4 = 4'b0000; hv4 = 4'b1011; hri4 = 1'b0;
        #1;
        chk("w4_ptr1_gid", 64'(gid4), FIXED ? 64'd0 : 64'd1);
        chk("w4_ptr1_dv",  64'(dvo4), 64'd0);
        cyc();
        hv4 = 4'b0000;

        // ---------------- reset mid-burst on the 2-channel instance ----------------
        hv2 = 2'b01; hd2 = 2'b00; hri2 = 1'b1; dv2 = 2'b00;
        #1;
        chk("mr_pre_gid", 64'(gid2), 64'd0);
        cyc();
        hv2 = 2'b10; hd2 = 2'b10;
        #1;
        chk("mr_hdr_gid", 64'(gid2), 64'd1);
        cyc();
        hv2 = 2'b11; dv2 = 2'b10; dt2[127:64] = 64'h30; l2 = 2'b00; dri2 = 1'b1;
        #1;
        chk("mr_b1_do", do2,       64'h30);
        chk("mr_b1_hr", 64'(hr2),  64'd0);
        cyc();
        dt2[127:64] = 64'h31; reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #1;
            chk("mr_rst_hv",  64'(hvo2), 64'd0);
            chk("mr_rst_dv",  64'(dvo2), 64'd0);
            chk("mr_rst_hr",  64'(hr2),  64'd0);
            chk("mr_rst_dr",  64'(dr2),  64'd0);
            chk("mr_rst_gid", 64'(gid2), 64'd0);
            cyc();
        end
        // Out of reset: e_ready with the pointer back at 0. The beats still
        // offered by the old message are not passed on.
        reset = 1'b0; hv2 = 2'b11; hd2 = 2'b00; hri2 = 1'b0;
        #1;
        chk("mr_post_hv",  64'(hvo2), 64'd1);
        chk("mr_post_dv",  64'(dvo2), 64'd0);
        chk("mr_post_dr",  64'(dr2),  64'd0);
        chk("mr_post_gid", 64'(gid2), 64'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
